// File: rtl/path_planner_bfs.sv
// Breadth-first shortest-path planner over the fixed 30-node arena graph.
// Searches SP->EP, backtracks the parent pointers, then streams the path SP first.
module path_planner_bfs #(
  parameter int NODES   = 30,
  parameter int MAX_LEN = 16
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] SP,
  input  logic [4:0] EP,
  output logic       path_input,
  output logic [4:0] path_planned,
  output logic [4:0] path_len,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int         N_EDGES   = 34;
  localparam logic [4:0] LAST_NODE = 5'(NODES - 1);
  localparam logic [5:0] LEN_LIMIT = 6'(MAX_LEN);

  // Undirected edge list, one {a, b} pair of node indices per 10 bits.
  localparam logic [N_EDGES*10-1:0] EDGE_LIST = {
    5'd0,  5'd1,  5'd1,  5'd2,  5'd1,  5'd29, 5'd2,  5'd3,  5'd2,  5'd8,
    5'd3,  5'd4,  5'd3,  5'd28, 5'd4,  5'd5,  5'd4,  5'd6,  5'd6,  5'd7,
    5'd7,  5'd8,  5'd8,  5'd9,  5'd8,  5'd12, 5'd9,  5'd10, 5'd9,  5'd11,
    5'd12, 5'd13, 5'd12, 5'd19, 5'd13, 5'd14, 5'd14, 5'd15, 5'd14, 5'd16,
    5'd16, 5'd17, 5'd16, 5'd18, 5'd18, 5'd19, 5'd19, 5'd20, 5'd20, 5'd21,
    5'd20, 5'd24, 5'd20, 5'd29, 5'd21, 5'd22, 5'd21, 5'd23, 5'd24, 5'd25,
    5'd25, 5'd26, 5'd26, 5'd27, 5'd26, 5'd28, 5'd28, 5'd29
  };

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_INIT, S_SEARCH, S_BACKTRACK, S_STREAM, S_FINISH, S_ERR
  } state_t;

  state_t           r_state, w_state_next;
  logic [4:0]       r_sp, r_ep;
  logic [4:0]       r_u, r_c;
  logic [4:0]       r_head, r_tail;
  logic [4:0]       r_bt, r_ptr, r_len;
  logic [NODES-1:0] r_visited;
  logic [4:0]       r_queue  [NODES];
  logic [4:0]       r_parent [NODES];
  logic [4:0]       r_stack  [NODES];
  logic             r_path_input;
  logic [4:0]       r_path_planned;
  logic             r_error;

  logic             w_adj, w_new, w_scan_last, w_q_nonempty;
  logic [5:0]       w_len_inc;
  logic [NODES-1:0] w_sp_onehot;

  // Edge lookup for the current (u, c) pair; the graph is undirected.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the block can leave a latch behind.
  always_comb begin
    w_adj = 1'b0;
    for (int k = 0; k < N_EDGES; k++) begin
      if ((r_u == EDGE_LIST[k*10+5 +: 5] && r_c == EDGE_LIST[k*10 +: 5]) ||
          (r_c == EDGE_LIST[k*10+5 +: 5] && r_u == EDGE_LIST[k*10 +: 5]))
        w_adj = 1'b1;
    end
  end

  assign w_new        = w_adj && !r_visited[r_c];
  assign w_scan_last  = (r_c == LAST_NODE);
  assign w_q_nonempty = (r_head != r_tail);
  assign w_len_inc    = {1'b0, r_len} + 6'd1;
  assign w_sp_onehot  = {{(NODES-1){1'b0}}, 1'b1} << r_sp;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:      if (start) w_state_next = S_CHECK;
      S_CHECK: begin
        if (r_sp > LAST_NODE || r_ep > LAST_NODE) w_state_next = S_ERR;
        else if (r_sp == r_ep)                    w_state_next = S_STREAM;
        else                                      w_state_next = S_INIT;
      end
      S_INIT:      w_state_next = S_SEARCH;
      S_SEARCH: begin
        if (w_new && r_c == r_ep)                         w_state_next = S_BACKTRACK;
        else if (w_scan_last && !w_q_nonempty && !w_new)  w_state_next = S_ERR;
      end
      S_BACKTRACK: begin
        if (w_len_inc > LEN_LIMIT) w_state_next = S_ERR;
        else if (r_bt == r_sp)     w_state_next = S_STREAM;
      end
      S_STREAM:    if (r_ptr == 5'd0) w_state_next = S_FINISH;
      S_FINISH:    w_state_next = S_IDLE;
      S_ERR:       w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_sp           <= '0;
      r_ep           <= '0;
      r_u            <= '0;
      r_c            <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_bt           <= '0;
      r_ptr          <= '0;
      r_len          <= '0;
      r_visited      <= '0;
      r_path_input   <= 1'b0;
      r_path_planned <= '0;
      r_error        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_path_input <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sp    <= SP;
            r_ep    <= EP;
            r_error <= 1'b0;
          end
        end
        S_CHECK: begin
          r_len <= (r_sp == r_ep) ? 5'd1 : 5'd0;
          r_ptr <= (r_sp == r_ep) ? 5'd1 : 5'd0;
        end
        S_INIT: begin
          // SP is dequeued immediately, so the scan of its row starts next cycle.
          r_visited <= w_sp_onehot;
          r_head    <= 5'd1;
          r_tail    <= 5'd1;
          r_u       <= r_sp;
          r_c       <= '0;
          r_bt      <= r_ep;
        end
        S_SEARCH: begin
          if (w_new) begin
            r_visited[r_c] <= 1'b1;
            r_tail         <= r_tail + 5'd1;
          end
          if (w_scan_last) begin
            r_c <= '0;
            if (w_q_nonempty) begin
              r_u    <= r_queue[r_head];
              r_head <= r_head + 5'd1;
            end else if (w_new) begin
              // Queue was empty but node 29 was just enqueued: bypass it.
              r_u    <= r_c;
              r_head <= r_head + 5'd1;
            end
          end else begin
            r_c <= r_c + 5'd1;
          end
        end
        S_BACKTRACK: begin
          r_ptr <= r_ptr + 5'd1;
          r_len <= r_len + 5'd1;
          r_bt  <= r_parent[r_bt];
        end
        S_STREAM: begin
          if (r_ptr != 5'd0) begin
            r_path_input   <= 1'b1;
            r_path_planned <= r_stack[r_ptr - 5'd1];
            r_ptr          <= r_ptr - 5'd1;
          end
        end
        default: ;
      endcase
      if (w_state_next == S_ERR) r_error <= 1'b1;
    end
  end

  // NOTE: the queue, parent and stack arrays are never reset; every entry is
  // written before it is read within a plan, and leaving them out of reset
  // lets them map onto plain storage.
  always_ff @(posedge clk_50M) begin
    if (r_state == S_CHECK) r_stack[0] <= r_sp;
    if (r_state == S_INIT)  r_queue[0] <= r_sp;
    if (r_state == S_SEARCH && w_new) begin
      r_parent[r_c]   <= r_u;
      r_queue[r_tail] <= r_c;
    end
    if (r_state == S_BACKTRACK) r_stack[r_ptr] <= r_bt;
  end

  assign path_input   = r_path_input;
  assign path_planned = r_path_planned;
  assign path_len     = r_len;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_FINISH) || (r_state == S_ERR);
  assign error        = r_error;

endmodule

// File: tb/tb_path_planner_bfs.sv
// Self-checking bench for path_planner_bfs: a queue-based BFS model predicts each
// plan and one monitor process checks every stream beat and done pulse against it.
module tb_path_planner_bfs;

  logic       clk_50M = 1'b0;
  logic       reset, start;
  logic [4:0] SP, EP;
  logic       path_input, busy, done, error;
  logic [4:0] path_planned, path_len;

  always #5 clk_50M = ~clk_50M;

  path_planner_bfs dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .start       (start),
    .SP          (SP),
    .EP          (EP),
    .path_input  (path_input),
    .path_planned(path_planned),
    .path_len    (path_len),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: arena graph and a textbook BFS with ascending neighbour order.
  int ea [34] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 6, 7, 8, 8, 9, 9, 12, 12,
                  13, 14, 14, 16, 16, 18, 19, 20, 20, 20, 21, 21, 24, 25, 26, 26, 28};
  int eb [34] = '{1, 2, 29, 3, 8, 4, 28, 5, 6, 7, 8, 9, 12, 10, 11, 13, 19,
                  14, 15, 16, 17, 18, 19, 20, 21, 24, 29, 22, 23, 25, 26, 27, 28, 29};
  bit adj [30][30];
  int exp_path[$];
  bit exp_err;

  task automatic model_plan(input int sp, input int ep);
    int  parent [30];
    bit  vis [30];
    int  q[$];
    bit  found;
    int  u;
    exp_path = {};
    exp_err  = 1'b0;
    if (sp >= 30 || ep >= 30) begin
      exp_err = 1'b1;
      return;
    end
    if (sp == ep) begin
      exp_path.push_back(sp);
      return;
    end
    foreach (vis[i]) vis[i] = 1'b0;
    vis[sp] = 1'b1;
    q.push_back(sp);
    found = 1'b0;
    while (q.size() > 0 && !found) begin
      u = q.pop_front();
      for (int c = 0; c < 30 && !found; c++) begin
        if (adj[u][c] && !vis[c]) begin
          vis[c]    = 1'b1;
          parent[c] = u;
          q.push_back(c);
          if (c == ep) found = 1'b1;
        end
      end
    end
    if (!found) begin
      exp_err = 1'b1;
      return;
    end
    for (int n = ep; n != sp; n = parent[n]) exp_path.push_front(n);
    exp_path.push_front(sp);
    if (exp_path.size() > 16) begin
      exp_err  = 1'b1;
      exp_path = {};
    end
  endtask

  // Monitor: samples 1 ns after each rising edge.
  bit mon_active = 1'b0;
  bit mon_done   = 1'b0;
  bit prev_pi    = 1'b0;
  int beat_idx   = 0;

  always @(posedge clk_50M) begin
    #1;
    if (reset) begin
      prev_pi = 1'b0;
    end else if (mon_active) begin
      if (path_input) begin
        if (beat_idx < exp_path.size()) begin
          check("beat_node", path_planned, exp_path[beat_idx]);
          check("beat_len", path_len, exp_path.size());
          check("beat_busy", busy, 1);
        end else begin
          check("beat_overrun", beat_idx, exp_path.size());
        end
        beat_idx++;
      end else if (beat_idx > 0 && beat_idx < exp_path.size()) begin
        check("stream_gap", beat_idx, exp_path.size());
      end
      if (done) begin
        check("done_error", error, exp_err);
        check("done_path_input", path_input, 0);
        check("done_beats", beat_idx, exp_err ? 0 : exp_path.size());
        if (!exp_err) begin
          check("done_after_last_beat", prev_pi, 1);
          check("hold_last_node", path_planned, exp_path[exp_path.size()-1]);
        end
        mon_active = 1'b0;
        mon_done   = 1'b1;
      end
      prev_pi = path_input;
    end else begin
      if (path_input) check("spurious_beat", path_input, 0);
      if (done)       check("spurious_done", done, 0);
      prev_pi = 1'b0;
    end
  end

  // Run one plan; optionally re-pulse start with other nodes pulse_at cycles later.
  task automatic run_plan(input int sp, input int ep, input int pulse_at, output int cycles);
    model_plan(sp, ep);
    beat_idx   = 0;
    mon_done   = 1'b0;
    mon_active = 1'b1;
    @(negedge clk_50M);
    SP = 5'(sp); EP = 5'(ep); start = 1'b1;
    @(negedge clk_50M);
    start  = 1'b0;
    cycles = 1;
    for (int i = 0; i < 2000 && !mon_done; i++) begin
      if (pulse_at > 0 && i == pulse_at) begin
        check("busy_at_repulse", busy, 1);
        SP = 5'd0; EP = 5'd20; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk_50M);
      cycles++;
    end
    start = 1'b0;
    check("plan_completed", mon_done, 1);
    repeat (3) @(negedge clk_50M);
    check("idle_after_plan", busy, 0);
  endtask

  int p_0_20 [4] = '{0, 1, 29, 20};
  int p_5_11 [7] = '{5, 4, 3, 2, 8, 9, 11};
  int cyc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 34; k++) begin
      adj[ea[k]][eb[k]] = 1'b1;
      adj[eb[k]][ea[k]] = 1'b1;
    end

    // Pin the model with hand-derived paths.
    model_plan(0, 20);
    check("model_len_0_20", exp_path.size(), 4);
    foreach (p_0_20[i]) check("model_node_0_20", exp_path[i], p_0_20[i]);
    model_plan(5, 11);
    check("model_len_5_11", exp_path.size(), 7);
    foreach (p_5_11[i]) check("model_node_5_11", exp_path[i], p_5_11[i]);
    model_plan(30, 3);
    check("model_err_30_3", exp_err, 1);

    reset = 1'b1; start = 1'b0; SP = '0; EP = '0;
    repeat (3) @(negedge clk_50M);
    check("rst_path_input", path_input, 0);
    check("rst_path_planned", path_planned, 0);
    check("rst_path_len", path_len, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clk_50M);

    run_plan(0, 20, 0, cyc);
    run_plan(5, 11, 0, cyc);
    run_plan(12, 12, 0, cyc);

    run_plan(30, 3, 0, cyc);
    check("err_within_3_cycles", cyc <= 3, 1);
    check("err_held_in_idle", error, 1);

    run_plan(12, 12, 0, cyc);
    check("err_cleared_by_start", error, 0);

    // Start pulsed mid-search must be ignored.
    run_plan(5, 11, 12, cyc);

    // Abort with reset after two stream beats.
    model_plan(0, 20);
    beat_idx   = 0;
    mon_done   = 1'b0;
    mon_active = 1'b1;
    @(negedge clk_50M);
    SP = 5'd0; EP = 5'd20; start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    for (int i = 0; i < 2000 && beat_idx < 2; i++) @(negedge clk_50M);
    check("abort_two_beats_seen", beat_idx, 2);
    mon_active = 1'b0;
    reset      = 1'b1;
    @(negedge clk_50M);
    check("abort_path_input", path_input, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk_50M);
    check("abort_no_done", mon_done, 0);

    run_plan(0, 20, 0, cyc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
